div_seq_radix2: RTL and testbench

- Iterative restoring radix-2 integer divider, one quotient bit per cycle.
- Sits directly downstream of the divide reservation station: it consumes one issued operand pair at a time and returns quotient and remainder for writeback.
- Implements RISC-V M-extension DIV/DIVU/REM/REMU semantics, including the divide-by-zero and signed-overflow special cases.
- Stalls in lock-step with the rest of the core via hci_rdy.

---
 rtl/div_seq_radix2.sv | 155 +++++++++++++++
 tb/tb_div_seq_radix2.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_radix2.sv
// rtl/div_seq_radix2.sv - iterative restoring radix-2 divider with RISC-V DIV/DIVU/REM/REMU semantics
//
// Purpose: accepts one operand pair at a time while idle, produces one
// quotient bit per active cycle, and returns quotient and remainder with a
// one-cycle out_en pulse. Divide-by-zero and signed overflow finish early.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   hci_rdy    global run enable; low freezes every register
//   in_en      operation request, honoured only in IDLE
//   a, b       dividend, divisor
//   div_signed 1 = two's-complement (DIV/REM), 0 = unsigned (DIVU/REMU)
//   out_en     one-active-cycle completion pulse
//   idle       combinational: unit can accept in_en this cycle
//   q, rem     quotient and remainder, held until the next completion

module div_seq_radix2 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hci_rdy,
  input  logic            in_en,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            div_signed,
  output logic            out_en,
  output logic            idle,
  output logic [XLEN-1:0] q,
  output logic [XLEN-1:0] rem
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [XLEN-1:0]   dvd_q;     // dividend shifting out / quotient shifting in
  logic [XLEN-1:0]   dvs_q;     // divisor magnitude
  logic [XLEN-1:0]   prem_q;    // partial remainder
  logic [CW-1:0]     cnt_q;
  logic              qneg_q;
  logic              rneg_q;
  logic              out_en_q;
  logic [XLEN-1:0]   q_q;
  logic [XLEN-1:0]   rem_q;

  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              b_zero;
  logic              ovf;
  logic [XLEN:0]     shift_w;
  logic [XLEN:0]     diff_w;
  logic              qbit;
  logic [XLEN-1:0]   prem_d;
  logic [XLEN-1:0]   dvd_d;

  // Magnitudes taken as unsigned, so the most negative value maps to 2^(XLEN-1).
  assign a_neg  = div_signed & a[XLEN-1];
  assign b_neg  = div_signed & b[XLEN-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);
  assign ovf    = div_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits XLEN+1 bits and the MSB of the difference is
  // an exact borrow flag.
  assign shift_w = {prem_q, dvd_q[XLEN-1]};
  assign diff_w  = shift_w - {1'b0, dvs_q};
  assign qbit    = ~diff_w[XLEN];
  assign prem_d  = qbit ? diff_w[XLEN-1:0] : {prem_q[XLEN-2:0], dvd_q[XLEN-1]};
  assign dvd_d   = {dvd_q[XLEN-2:0], qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      prem_q   <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      out_en_q <= 1'b0;
      q_q      <= '0;
      rem_q    <= '0;
    end else if (hci_rdy) begin
      out_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_en) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            if (b_zero) begin
              // Special results are staged in the datapath registers.
              dvd_q   <= '1;
              prem_q  <= a;
              state_q <= S_DONE;
            end else if (ovf) begin
              dvd_q   <= a;
              prem_q  <= '0;
              state_q <= S_DONE;
            end else begin
              dvd_q   <= a_mag;
              dvs_q   <= b_mag;
              qneg_q  <= a_neg ^ b_neg;
              rneg_q  <= a_neg;
              prem_q  <= '0;
              cnt_q   <= '0;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          dvd_q  <= dvd_d;
          prem_q <= prem_d;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          q_q      <= qneg_q ? -dvd_q : dvd_q;
          rem_q    <= rneg_q ? -prem_q : prem_q;
          out_en_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        S_DONE: begin
          q_q      <= dvd_q;
          rem_q    <= prem_q;
          out_en_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Drops in the same cycle as in_en so upstream cannot issue twice.
  assign idle   = (state_q == S_IDLE) && !in_en;
  assign out_en = out_en_q;
  assign q      = q_q;
  assign rem    = rem_q;

endmodule

// File: tb/tb_div_seq_radix2.sv
// tb/tb_div_seq_radix2.sv - directed self-checking bench for div_seq_radix2

module tb_div_seq_radix2;

  logic        clk;
  logic        rst;
  logic        hci_rdy;
  logic        in_en;
  logic [31:0] a;
  logic [31:0] b;
  logic        div_signed;
  logic        out_en;
  logic        idle;
  logic [31:0] q;
  logic [31:0] rem;

  int errors;
  int checks;

  div_seq_radix2 #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .hci_rdy    (hci_rdy),
    .in_en      (in_en),
    .a          (a),
    .b          (b),
    .div_signed (div_signed),
    .out_en     (out_en),
    .idle       (idle),
    .q          (q),
    .rem        (rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic issue(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                       input logic s);
    a = ia;
    b = ib;
    div_signed = s;
    in_en = 1'b1;
    #1;
    chk({tag, "_idle_low"}, {31'd0, idle}, 32'd0);
    @(posedge clk);
    #1;
    in_en = 1'b0;
    chk({tag, "_acc_out_en"}, {31'd0, out_en}, 32'd0);
  endtask

  // n0 = active edges already counted since the accepting edge.
  task automatic complete(input string tag, input int n0, input int exp_lat,
                          input logic [31:0] eq, input logic [31:0] er);
    int n;
    n = n0;
    while (!out_en && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_rem"}, rem, er);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (out_en) pulses++;
    end
  endtask

  initial begin
    int n;
    int p;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    hci_rdy = 1'b1;
    in_en = 1'b0;
    a = '0;
    b = '0;
    div_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_en", {31'd0, out_en}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_q", q, 32'd0);
    chk("rst_rem", rem, 32'd0);

    // Signed normal cases, each issued in the previous out_en cycle.
    issue("s100_7", 32'd100, 32'd7, 1'b1);
    complete("s100_7", 0, 33, 32'd14, 32'd2);
    chk("out_idle_high", {31'd0, idle}, 32'd1);
    issue("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    complete("sm7_2", 0, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    issue("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    complete("s7_m2", 0, 33, 32'hFFFF_FFFD, 32'd1);
    @(posedge clk);
    #1;
    chk("pulse_1cyc", {31'd0, out_en}, 32'd0);

    // Early-out cases.
    issue("s5_0", 32'd5, 32'd0, 1'b1);
    complete("s5_0", 0, 1, 32'hFFFF_FFFF, 32'd5);
    issue("u5_0", 32'd5, 32'd0, 1'b0);
    complete("u5_0", 0, 1, 32'hFFFF_FFFF, 32'd5);
    issue("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    complete("s_ovf", 0, 1, 32'h8000_0000, 32'd0);

    // Unsigned range.
    issue("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    complete("u_ovf", 0, 33, 32'd0, 32'h8000_0000);
    issue("u_max_2", 32'hFFFF_FFFF, 32'd2, 1'b0);
    complete("u_max_2", 0, 33, 32'h7FFF_FFFF, 32'd1);
    @(posedge clk);
    #1;

    // Request while busy must be ignored.
    issue("busy", 32'd9, 32'd3, 1'b0);
    n = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      n++;
    end
    a = 32'd50;
    b = 32'd5;
    in_en = 1'b1;
    #1;
    chk("busy_idle_low", {31'd0, idle}, 32'd0);
    @(posedge clk);
    #1;
    n++;
    in_en = 1'b0;
    complete("busy", n, 33, 32'd3, 32'd0);
    count_pulses(40, p);
    chk("busy_extra_pulse", p, 0);

    // Stall 10 cycles mid-CALC and 3 cycles on the out_en pulse.
    issue("stall", 32'd100, 32'd7, 1'b1);
    n = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      n++;
    end
    hci_rdy = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      n++;
    end
    hci_rdy = 1'b1;
    complete("stall", n, 43, 32'd14, 32'd2);
    hci_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_hold_out_en", {31'd0, out_en}, 32'd1);
    end
    hci_rdy = 1'b1;
    chk("stall_active_out_en", {31'd0, out_en}, 32'd1);
    chk("stall_hold_q", q, 32'd14);
    @(posedge clk);
    #1;
    chk("stall_pulse_end", {31'd0, out_en}, 32'd0);

    // Reset at iteration 10 discards the operation.
    issue("rst_mid", 32'd100, 32'd7, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_idle", {31'd0, idle}, 32'd1);
    chk("rst_mid_out_en", {31'd0, out_en}, 32'd0);
    chk("rst_mid_q", q, 32'd0);
    chk("rst_mid_rem", rem, 32'd0);
    count_pulses(40, p);
    chk("rst_mid_no_pulse", p, 0);
    issue("post_rst", 32'd9, 32'd3, 1'b1);
    complete("post_rst", 0, 33, 32'd3, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
